requant_writeback: RTL

- Downstream stage of the INT8 matmul accelerator.
- Consumes each 4-lane INT32 accumulator result and applies per-lane bias, fixed-point scale, rounding shift, zero-point and optional ReLU.
- Saturates each lane to INT8, packs four outputs into one 32-bit word, and gathers four words into a 128-bit line.
- Writes lines back to data memory through a 128-bit DMA write port.
- Lets the CPU chain layer outputs without reading RESULT0–3 over MMIO.

---
 rtl/requant_pkg.sv | 31 +++
 rtl/requant_lane.sv | 75 +++++++
 rtl/requant_writeback.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/requant_pkg.sv
// Shared definitions for the requantise/write-back stage.
//   LINE_BYTES       : bytes per DMA write line
//   INT8_MIN/INT8_MAX: output saturation bounds
//   wstate_t         : writer FSM states
//   sat_int8()       : clamp a wide signed value to INT8
//   be_mask()        : byte enables for a line holding n 32-bit words
package requant_pkg;

  localparam int LINE_BYTES = 16;
  localparam logic signed [7:0] INT8_MIN = -8'sd128;
  localparam logic signed [7:0] INT8_MAX = 8'sd127;

  typedef enum logic [1:0] {W_FILL, W_ISSUE, W_WAIT} wstate_t;

  function automatic logic signed [7:0] sat_int8(input logic signed [47:0] v);
    if (v > 48'sd127) return INT8_MAX;
    else if (v < -48'sd128) return INT8_MIN;
    else return $signed(v[7:0]);
  endfunction

  function automatic logic [15:0] be_mask(input logic [2:0] n);
    case (n)
      3'd0:    return 16'h0000;
      3'd1:    return 16'h000F;
      3'd2:    return 16'h00FF;
      3'd3:    return 16'h0FFF;
      default: return 16'hFFFF;
    endcase
  endfunction

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantisation datapath (three registered stages).
//   clk   : clock
//   en    : advance enable; low freezes all three stages
//   acc   : signed INT32 accumulator
//   bias  : signed INT32 bias
//   mult  : signed scale multiplier
//   shift : arithmetic right shift, 0..31
//   zp    : signed INT8 zero-point
//   relu  : clamp at zp (only built when REQUANT_RELU_EN is defined)
//   q     : saturated INT8 result, valid three advances after acc
// Data registers carry no reset; validity is tracked by the caller.
module requant_lane
  import requant_pkg::*;
(
  input  logic        clk,
  input  logic        en,
  input  logic [31:0] acc,
  input  logic [31:0] bias,
  input  logic [15:0] mult,
  input  logic [4:0]  shift,
  input  logic [7:0]  zp,
  input  logic        relu,
  output logic [7:0]  q
);

  logic signed [31:0] b_p1;
  logic signed [47:0] p_p2;
  logic signed [7:0]  q_p3;
  logic signed [47:0] r_p2;
  logic signed [47:0] y_p2;
  logic signed [47:0] zp_ext;

  function automatic logic signed [31:0] sat_int32(input logic signed [32:0] s);
    // Overflow shows up as disagreement between the two top bits.
    if (s[32] != s[31]) return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    else return $signed(s[31:0]);
  endfunction

  function automatic logic signed [47:0] round_shift(input logic signed [47:0] p,
                                                      input logic [4:0] sh);
    logic signed [47:0] half;
    if (sh == 5'd0) return p;
    half = 48'sd1 <<< (sh - 5'd1);
    return (p + half) >>> sh;
  endfunction

  assign zp_ext = $signed({{40{zp[7]}}, zp});

  always_comb begin
    r_p2 = round_shift(p_p2, shift);
    y_p2 = r_p2 + zp_ext;
`ifdef REQUANT_RELU_EN
    if (relu && (y_p2 < zp_ext)) y_p2 = zp_ext;
`endif
  end

`ifndef REQUANT_RELU_EN
  logic unused_relu;
  assign unused_relu = relu;
`endif

  always_ff @(posedge clk) begin
    if (en) begin
      // P1: bias add, saturated to INT32
      b_p1 <= sat_int32($signed({acc[31], acc}) + $signed({bias[31], bias}));
      // P2: scale product
      p_p2 <= $signed({{16{b_p1[31]}}, b_p1}) * $signed({{32{mult[15]}}, mult});
      // P3: round, zero-point, optional ReLU, saturate
      q_p3 <= sat_int8(y_p2);
    end
  end

  assign q = q_p3;

endmodule

// File: rtl/requant_writeback.sv
// Requantise 4-lane INT32 accumulator beats to INT8, pack four bytes per
// word, gather four words per 128-bit line and write lines to memory.
// Optional feature macro: REQUANT_RELU_EN (honours cfg_relu when defined).
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   cfg_start             : load out_base into the pointer, clear line/counter
//   cfg_flush             : write any partial line once the pipeline drains
//   cfg_out_base          : 16-byte-aligned output byte address
//   cfg_bias/mult/shift/zp/relu : requantisation parameters (held while busy)
//   in_valid/in_ready/in_acc    : accumulator beat handshake
//   wr_valid/wr_ready/wr_addr/wr_data/wr_be : line write port
//   busy                  : pipeline, line buffer or write outstanding
//   flush_done            : one-cycle pulse when a flush completes
//   words_out             : words committed since cfg_start
module requant_writeback
  import requant_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int MULT_W     = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_start,
  input  logic                cfg_flush,
  input  logic [31:0]         cfg_out_base,
  input  logic [127:0]        cfg_bias,
  input  logic [MULT_W-1:0]   cfg_mult,
  input  logic [4:0]          cfg_shift,
  input  logic [7:0]          cfg_zp,
  input  logic                cfg_relu,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_acc,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [31:0]         wr_addr,
  output logic [127:0]        wr_data,
  output logic [15:0]         wr_be,
  output logic                busy,
  output logic                flush_done,
  output logic [31:0]         words_out
);

  wstate_t     state;
  logic        vld_p1, vld_p2, vld_p3;
  logic [2:0]  cnt;
  logic [31:0] ptr;
  logic        flush_pend;
  logic [31:0] line_q [LINE_WORDS];
  logic [31:0] word;

  logic        stall, advance, accept, pack, pipe_empty, flush_req, start_ok;
  logic [2:0]  issue_n;
  logic [127:0] issue_data;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    requant_lane u_lane (
      .clk   (clk),
      .en    (advance),
      .acc   (in_acc[32*i +: 32]),
      .bias  (cfg_bias[32*i +: 32]),
      .mult  (cfg_mult),
      .shift (cfg_shift),
      .zp    (cfg_zp),
      .relu  (cfg_relu),
      .q     (word[8*i +: 8])
    );
  end

  // The whole pipeline freezes only when a finished beat sits in P3 and the
  // line buffer is tied up by an outstanding write; bubbles still advance.
  assign stall      = vld_p3 && (state != W_FILL);
  assign advance    = !stall;
  assign in_ready   = advance;
  assign accept     = in_valid && in_ready;
  assign pack       = vld_p3 && advance;
  assign pipe_empty = !(vld_p1 || vld_p2 || vld_p3);
  assign flush_req  = flush_pend || cfg_flush;
  assign busy       = !pipe_empty || (cnt != 3'd0) || (state != W_FILL);
  assign start_ok   = cfg_start && !busy;

  // Line image as it will be written: includes the word packed this cycle,
  // unused slots zeroed.
  always_comb begin
    issue_n    = pack ? cnt + 3'd1 : cnt;
    issue_data = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      if (3'(i) < issue_n)
        issue_data[32*i +: 32] = (pack && cnt == 3'(i)) ? word : line_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (pack) line_q[cnt[1:0]] <= word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= W_FILL;
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      vld_p3     <= 1'b0;
      cnt        <= 3'd0;
      ptr        <= 32'd0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      words_out  <= 32'd0;
      wr_valid   <= 1'b0;
      wr_addr    <= 32'd0;
      wr_data    <= '0;
      wr_be      <= 16'd0;
    end else begin
      flush_done <= 1'b0;
      flush_pend <= flush_req;

      if (advance) begin
        vld_p1 <= accept;
        vld_p2 <= vld_p1;
        vld_p3 <= vld_p2;
      end

      case (state)
        W_FILL: begin
          if (pack) begin
            cnt <= cnt + 3'd1;
            if (cnt == 3'd3) begin
              state    <= W_ISSUE;
              wr_valid <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= issue_data;
              wr_be    <= be_mask(issue_n);
            end
          end else if (flush_req && pipe_empty) begin
            if (cnt != 3'd0) begin
              state    <= W_ISSUE;
              wr_valid <= 1'b1;
              wr_addr  <= ptr;
              wr_data  <= issue_data;
              wr_be    <= be_mask(issue_n);
            end else begin
              flush_done <= 1'b1;
              flush_pend <= 1'b0;
            end
          end
          if (start_ok) begin
            ptr       <= cfg_out_base;
            cnt       <= 3'd0;
            words_out <= 32'd0;
          end
        end
        W_ISSUE, W_WAIT: begin
          if (wr_ready) begin
            state     <= W_FILL;
            wr_valid  <= 1'b0;
            ptr       <= ptr + 32'(LINE_BYTES);
            words_out <= words_out + {29'd0, cnt};
            cnt       <= 3'd0;
          end else begin
            state <= W_WAIT;
          end
        end
        default: state <= W_FILL;
      endcase
    end
  end

endmodule
